// File: rtl/window_fetch_pkg.sv
// rtl/window_fetch_pkg.sv - shared types and constants for the window fetch block
package window_fetch_pkg;

  // One signed pixel; four of them are packed into each 32-bit buffer word
  typedef logic signed [7:0] int8_t;

  // Number of image rows covered by one window
  localparam int WIN_ROWS = 4;

  // Pixels packed into one 32-bit activation-buffer word
  localparam int PIX_PER_WORD = 4;

  // Width of the row index within a window
  localparam int ROW_IDX_W = $clog2(WIN_ROWS);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_LAUNCH    = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_NEXT      = 3'd5,
    ST_FIN       = 3'd6
  } fetch_state_t;

endpackage

// File: rtl/window_fetch_row_regs.sv
// rtl/window_fetch_row_regs.sv - four-row window register file written by row index
module window_row_regs
  import window_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ROW_IDX_W-1:0] wr_idx,
  input  logic [31:0]          wr_data,
  output logic [31:0]          row0,
  output logic [31:0]          row1,
  output logic [31:0]          row2,
  output logic [31:0]          row3
);

  logic [31:0] rows [WIN_ROWS];

  // Each returning read word lands in the row slot of the read that fetched it
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIN_ROWS; i++) begin
        rows[i] <= '0;
      end
    end else if (wr_en) begin
      rows[wr_idx] <= wr_data;
    end
  end

  assign row0 = rows[0];
  assign row1 = rows[1];
  assign row2 = rows[2];
  assign row3 = rows[3];

endmodule

// File: rtl/window_fetch.sv
// rtl/window_fetch.sv - fetches 4-row windows from the activation buffer and launches the sliding-window stage
module window_fetch
  import window_fetch_pkg::*;
#(
  parameter int W_WORDS = 4,
  parameter int IMG_H   = 8,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       A0_in,
  output logic [31:0]       A1_in,
  output logic [31:0]       A2_in,
  output logic [31:0]       A3_in,
  output logic              sw_start,
  input  logic              sw_done,
  output logic              busy,
  output logic              frame_done
);

  // Reject parameter sets whose frame does not fit the address space or cannot hold a window
  if (IMG_H < WIN_ROWS || W_WORDS < 1 ||
      (64'(IMG_H) * 64'(W_WORDS)) > (64'd1 << ADDR_W)) begin : g_bad_params
    $error("window_fetch: illegal W_WORDS/IMG_H/ADDR_W combination");
  end

  localparam logic [ADDR_W-1:0]    W_A    = ADDR_W'(W_WORDS);
  localparam logic [ADDR_W-1:0]    LAST_R = ADDR_W'(IMG_H - WIN_ROWS);
  localparam logic [ADDR_W-1:0]    LAST_C = ADDR_W'(W_WORDS - 1);
  localparam logic [ADDR_W-1:0]    ONE_A  = ADDR_W'(1);
  localparam logic [ROW_IDX_W-1:0] LAST_K = ROW_IDX_W'(WIN_ROWS - 1);
  localparam logic [ROW_IDX_W-1:0] ONE_K  = ROW_IDX_W'(1);

  fetch_state_t         state;
  logic [ADDR_W-1:0]    r;
  logic [ADDR_W-1:0]    c;
  logic [ROW_IDX_W-1:0] k;
  logic                 sw_done_q;
  logic                 rd_valid;
  logic [ROW_IDX_W-1:0] rd_idx;

  // Word address of row kk of the window whose top-left word is (rr, cc)
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0]    rr,
                                                  input logic [ROW_IDX_W-1:0] kk,
                                                  input logic [ADDR_W-1:0]    cc);
    return (rr + ADDR_W'(kk)) * W_A + cc;
  endfunction

  // Window sequencer; all outputs are registered alongside the state so they switch with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      r          <= '0;
      c          <= '0;
      k          <= '0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      sw_start   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sw_done_q  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_idx     <= '0;
    end else begin
      sw_done_q <= sw_done;
      // Data returns one cycle after the read, so remember which row it belongs to
      rd_valid  <= mem_re;
      rd_idx    <= k;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_READ;
            r        <= '0;
            c        <= '0;
            k        <= '0;
            mem_re   <= 1'b1;
            mem_addr <= word_addr('0, '0, '0);
            busy     <= 1'b1;
          end
        end
        ST_READ: begin
          if (k == LAST_K) begin
            state    <= ST_CAPTURE;
            k        <= '0;
            mem_re   <= 1'b0;
            mem_addr <= '0;
          end else begin
            k        <= k + ONE_K;
            mem_addr <= word_addr(r, k + ONE_K, c);
          end
        end
        ST_CAPTURE: begin
          // The last row is written at the end of this cycle
          state    <= ST_LAUNCH;
          sw_start <= 1'b1;
        end
        ST_LAUNCH: begin
          state    <= ST_WAIT_DONE;
          sw_start <= 1'b0;
        end
        ST_WAIT_DONE: begin
          // A level left high from the previous window is not a new completion
          if (sw_done && !sw_done_q) begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (r == LAST_R && c == LAST_C) begin
            state      <= ST_FIN;
            frame_done <= 1'b1;
          end else begin
            state  <= ST_READ;
            k      <= '0;
            mem_re <= 1'b1;
            if (c == LAST_C) begin
              c        <= '0;
              r        <= r + ONE_A;
              mem_addr <= word_addr(r + ONE_A, '0, '0);
            end else begin
              c        <= c + ONE_A;
              mem_addr <= word_addr(r, '0, c + ONE_A);
            end
          end
        end
        ST_FIN: begin
          state      <= ST_IDLE;
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  window_row_regs u_rows (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rd_valid),
    .wr_idx  (rd_idx),
    .wr_data (mem_rdata),
    .row0    (A0_in),
    .row1    (A1_in),
    .row2    (A2_in),
    .row3    (A3_in)
  );

endmodule

// File: tb/tb_window_fetch.sv
// tb/tb_window_fetch.sv - self-checking bench for window_fetch
module tb_window_fetch;

  localparam int W  = 2;
  localparam int H  = 5;
  localparam int AW = 16;

  typedef logic [3:0][31:0] win_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic [31:0]   A0_in, A1_in, A2_in, A3_in;
  logic          sw_start;
  logic          sw_done;
  logic          busy;
  logic          frame_done;

  int checks     = 0;
  int failures   = 0;
  int reads_seen = 0;
  int launches   = 0;
  int fd_count   = 0;

  int   exp_addr[$];
  win_t exp_win[$];

  always #5 clk = ~clk;

  window_fetch #(.W_WORDS(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .A0_in      (A0_in),
    .A1_in      (A1_in),
    .A2_in      (A2_in),
    .A3_in      (A3_in),
    .sw_start   (sw_start),
    .sw_done    (sw_done),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Buffer returns its own address one cycle after a read, junk otherwise
  always @(posedge clk) mem_rdata <= mem_re ? {16'h0, mem_addr} : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reads and launched windows for a whole frame, in order
  task automatic build_frame();
    win_t w;
    exp_addr.delete();
    exp_win.delete();
    for (int rr = 0; rr <= H - 4; rr++) begin
      for (int cc = 0; cc < W; cc++) begin
        for (int kk = 0; kk < 4; kk++) begin
          exp_addr.push_back((rr + kk) * W + cc);
          w[kk] = 32'((rr + kk) * W + cc);
        end
        exp_win.push_back(w);
      end
    end
    reads_seen = 0;
    launches   = 0;
    fd_count   = 0;
  endtask

  // Every read address and every launched window is compared against the model
  always @(negedge clk) begin
    win_t w;
    if (!reset) begin
      if (mem_re) begin
        reads_seen++;
        check("read_expected", 32'(exp_addr.size() != 0), 32'd1);
        if (exp_addr.size() != 0) check("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
      end
      if (sw_start) begin
        launches++;
        check("launch_expected", 32'(exp_win.size() != 0), 32'd1);
        if (exp_win.size() != 0) begin
          w = exp_win.pop_front();
          check("A0_in", A0_in, w[0]);
          check("A1_in", A1_in, w[1]);
          check("A2_in", A2_in, w[2]);
          check("A3_in", A3_in, w[3]);
        end
      end
      if (frame_done) begin
        fd_count++;
        check("frame_done_after_all", 32'(exp_addr.size() + exp_win.size()), 32'd0);
      end
    end
  end

  task automatic wait_sw_start();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sw_start && n < 100);
    check("sw_start_seen", 32'(sw_start), 32'd1);
  endtask

  task automatic done_pulse();
    @(negedge clk) sw_done = 1'b0;
    @(negedge clk) sw_done = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic finish_frame_checks();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    check("frame_done_seen", 32'(frame_done), 32'd1);
    repeat (3) @(negedge clk);
    check("frame_done_count", 32'(fd_count), 32'd1);
    check("launch_count", 32'(launches), 32'd4);
    check("read_count", 32'(reads_seen), 32'd16);
    check("busy_after_frame", 32'(busy), 32'd0);
  endtask

  initial begin
    int   lit [16] = '{0, 2, 4, 6, 1, 3, 5, 7, 2, 4, 6, 8, 3, 5, 7, 9};
    bit   exp_re [6] = '{1, 1, 1, 1, 0, 0};
    bit   exp_sw [6] = '{0, 0, 0, 0, 0, 1};
    int   r0;
    int   fd0;
    int   n;

    reset   = 1'b1;
    start   = 1'b0;
    sw_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_sw_start", 32'(sw_start), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_rows", A0_in | A1_in | A2_in | A3_in, 32'd0);
    reset = 1'b0;

    // Model pinned against the hand-derived address list
    build_frame();
    for (int i = 0; i < 16; i++) check("model_addr", 32'(exp_addr[i]), 32'(lit[i]));

    // Start-to-read and start-to-launch latency
    @(negedge clk) start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      check("lat_mem_re", 32'(mem_re), 32'(exp_re[i-1]));
      check("lat_sw_start", 32'(sw_start), 32'(exp_sw[i-1]));
    end
    check("w0_A0", A0_in, 32'd0);
    check("w0_A1", A1_in, 32'd2);
    check("w0_A2", A2_in, 32'd4);
    check("w0_A3", A3_in, 32'd6);

    // Rows hold while waiting; start during WAIT_DONE is ignored
    repeat (5) @(negedge clk);
    check("hold_A0", A0_in, 32'd0);
    check("hold_A3", A3_in, 32'd6);
    check("hold_busy", 32'(busy), 32'd1);
    check("hold_no_read", 32'(reads_seen), 32'd4);
    pulse_start();
    done_pulse();

    // sw_done stays high across window 1's launch: no advance until it re-rises
    wait_sw_start();
    r0 = reads_seen;
    repeat (8) @(negedge clk);
    check("stale_no_advance", 32'(reads_seen), 32'(r0));
    check("stale_launches", 32'(launches), 32'd2);
    done_pulse();
    wait_sw_start();
    done_pulse();
    wait_sw_start();
    done_pulse();
    finish_frame_checks();

    // Abort during window 2's reads
    build_frame();
    pulse_start();
    wait_sw_start();
    done_pulse();
    wait_sw_start();
    done_pulse();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_re && n < 100);
    check("abort_in_read", 32'(mem_re), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_re", 32'(mem_re), 32'd0);
    reset = 1'b0;
    fd0 = fd_count;
    repeat (10) @(negedge clk);
    check("abort_no_frame_done", 32'(fd_count), 32'(fd0));
    check("abort_idle", 32'(busy), 32'd0);

    // Restart after abort begins again at address 0 and completes normally
    build_frame();
    sw_done = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("restart_mem_re", 32'(mem_re), 32'd1);
    check("restart_addr0", 32'(mem_addr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      wait_sw_start();
      done_pulse();
    end
    finish_frame_checks();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
